cplx_frame_capture: RTL and testbench

//  Sink end of the data_* complex stream interface (I/Q/en/sof/eof) used by cplx_conj and its peers.

---
 rtl/cplx_frame_capture_if.sv | 32 +++
 rtl/cplx_frame_capture.sv | 145 ++++++++++++++
 tb/tb_cplx_frame_capture.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cplx_frame_capture_if.sv
// Bundle for the complex capture sink: stream in (I/Q/en/sof/eof), arm control, valid/ready read port and status.
// The capture block takes the slave view; the producer/reader side takes the master view.
interface cplx_frame_capture_if #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 10
);
  logic [DATA_SIZE-1:0] data_i_i;
  logic [DATA_SIZE-1:0] data_q_i;
  logic                 data_en_i;
  logic                 data_sof_i;
  logic                 data_eof_i;
  logic                 arm_i;
  logic                 rd_ready_i;
  logic [DATA_SIZE-1:0] rd_i_o;
  logic [DATA_SIZE-1:0] rd_q_o;
  logic                 rd_valid_o;
  logic                 rd_last_o;
  logic [ADDR_SIZE:0]   rd_count_o;
  logic                 busy_o;
  logic                 trunc_o;
  logic                 done_o;

  modport master (
    output data_i_i, data_q_i, data_en_i, data_sof_i, data_eof_i, arm_i, rd_ready_i,
    input  rd_i_o, rd_q_o, rd_valid_o, rd_last_o, rd_count_o, busy_o, trunc_o, done_o
  );

  modport slave (
    input  data_i_i, data_q_i, data_en_i, data_sof_i, data_eof_i, arm_i, rd_ready_i,
    output rd_i_o, rd_q_o, rd_valid_o, rd_last_o, rd_count_o, busy_o, trunc_o, done_o
  );
endinterface

// File: rtl/cplx_frame_capture.sv
// Arm-triggered capture of one I/Q frame into RAM, then in-order drain over valid/ready.
// First drained sample is valid 2 cycles after the final write; full-throughput prefetch, holds under stall.
module cplx_frame_capture #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 10,
  parameter int FRAME_LEN = 1024,
  parameter int USE_SOF   = 1
) (
  input logic                  data_clk_i,
  input logic                  data_rst_i,
  cplx_frame_capture_if.slave  bus
);
  localparam int CW = ADDR_SIZE + 1;
  localparam int SW = 2 * DATA_SIZE;
  localparam logic [CW-1:0] FLEN = CW'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            trunc_q, trunc_d;
  logic            done_q, done_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic [SW-1:0]   rd_dat_q, rd_dat_d;

  logic [SW-1:0]        mem [2**ADDR_SIZE];
  logic                 wr_en;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [SW-1:0]        wr_dat;
  logic                 start;
  logic                 load;
  logic                 rd_hs;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    trunc_d    = trunc_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_dat_d   = rd_dat_q;
    wr_en      = 1'b0;
    wr_addr    = count_q[ADDR_SIZE-1:0];
    wr_dat     = {bus.data_i_i, bus.data_q_i};
    start      = bus.data_en_i && (bus.data_sof_i || (USE_SOF == 0));
    rd_hs      = rd_valid_q && bus.rd_ready_i;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        // an arm coinciding with the done pulse belongs to the frame just finished
        if (bus.arm_i && !done_q) begin
          state_d  = WAIT_SOF;
          count_d  = '0;
          rd_ptr_d = '0;
          trunc_d  = 1'b0;
        end
      end
      WAIT_SOF: begin
        if (start) begin
          wr_en   = 1'b1;
          count_d = CW'(1);
          if (FRAME_LEN == 1) begin
            state_d = DRAIN;
          end else if (bus.data_eof_i) begin
            state_d = DRAIN;
            trunc_d = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (bus.data_en_i) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          if (count_d == FLEN) begin
            state_d = DRAIN;
          end else if (bus.data_eof_i) begin
            state_d = DRAIN;
            trunc_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // refill the output register whenever it is empty or being consumed
        load = (!rd_valid_q || bus.rd_ready_i) && (rd_ptr_q < count_q);
        if (load) begin
          rd_dat_d   = mem[rd_ptr_q[ADDR_SIZE-1:0]];
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_ptr_q + CW'(1)) == count_q;
          rd_ptr_d   = rd_ptr_q + CW'(1);
        end else if (rd_hs) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
        if (rd_hs && rd_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge data_clk_i or posedge data_rst_i) begin
    if (data_rst_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      trunc_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      trunc_q    <= trunc_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_dat_q   <= rd_dat_d;
    end
  end

  always_ff @(posedge data_clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign bus.rd_i_o     = rd_dat_q[SW-1:DATA_SIZE];
  assign bus.rd_q_o     = rd_dat_q[DATA_SIZE-1:0];
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_last_o  = rd_last_q;
  assign bus.rd_count_o = count_q;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.trunc_o    = trunc_q;
  assign bus.done_o     = done_q;
endmodule

// File: tb/tb_cplx_frame_capture.sv
// Directed bench: table of capture scenarios on an 8-sample SOF-aligned instance,
// plus hand sequences for async reset mid-drain and a 1-sample free-running instance.
module tb_cplx_frame_capture;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cplx_frame_capture_if #(.DATA_SIZE(16), .ADDR_SIZE(4)) ifa ();
  cplx_frame_capture_if #(.DATA_SIZE(16), .ADDR_SIZE(4)) ifb ();

  cplx_frame_capture #(.DATA_SIZE(16), .ADDR_SIZE(4), .FRAME_LEN(8), .USE_SOF(1)) dut_a (
    .data_clk_i(clk), .data_rst_i(rst), .bus(ifa)
  );
  cplx_frame_capture #(.DATA_SIZE(16), .ADDR_SIZE(4), .FRAME_LEN(1), .USE_SOF(0)) dut_b (
    .data_clk_i(clk), .data_rst_i(rst), .bus(ifb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    n_idle;     // en without sof before the frame start
    int    n_samp;     // samples sent from the sof onward
    int    eof_at;     // 1-based sample carrying eof, 0 = none
    int    base;       // sample k carries I=base+k, Q=-(base+k)
    bit    bp;         // reader ready pattern 1,0,0,1 instead of always ready
    bit    disturb;    // arm during capture and drain, sof mid-capture
    int    exp_count;
    bit    exp_trunc;
  } vec_t;

  vec_t vecs[4];

  task automatic clear_a();
    ifa.data_en_i  = 1'b0;
    ifa.data_sof_i = 1'b0;
    ifa.data_eof_i = 1'b0;
    ifa.data_i_i   = '0;
    ifa.data_q_i   = '0;
    ifa.arm_i      = 1'b0;
  endtask

  task automatic run_row(input vec_t v);
    int got;
    int dones;
    logic pstall;
    logic [15:0] pi, pq, ei, eq;
    got = 0;
    dones = 0;
    pstall = 1'b0;
    pi = '0;
    pq = '0;
    ifa.rd_ready_i = 1'b0;
    @(negedge clk);
    ifa.arm_i = 1'b1;
    @(negedge clk);
    ifa.arm_i = 1'b0;
    chk({v.name, "_trunc_after_arm"}, 32'(ifa.trunc_o), 32'd0);
    chk({v.name, "_busy_after_arm"}, 32'(ifa.busy_o), 32'd1);
    for (int i = 0; i < v.n_idle; i++) begin
      ifa.data_en_i  = 1'b1;
      ifa.data_sof_i = 1'b0;
      ifa.data_eof_i = 1'b0;
      ifa.data_i_i   = 16'hDEAD;
      ifa.data_q_i   = 16'hBEEF;
      @(negedge clk);
    end
    for (int k = 0; k < v.n_samp; k++) begin
      ifa.data_en_i  = 1'b1;
      ifa.data_sof_i = (k == 0) || (v.disturb && k == 4);
      ifa.data_eof_i = (v.eof_at == k + 1);
      ifa.data_i_i   = 16'(v.base + k);
      ifa.data_q_i   = -16'(v.base + k);
      ifa.arm_i      = v.disturb && (k == 3);
      @(negedge clk);
    end
    clear_a();
    for (int c = 0; c < 60; c++) begin
      if (ifa.done_o) dones++;
      if (pstall) begin
        chk({v.name, "_stall_hold"}, {ifa.rd_i_o, ifa.rd_q_o}, {pi, pq});
        chk({v.name, "_stall_valid"}, 32'(ifa.rd_valid_o), 32'd1);
      end
      ifa.rd_ready_i = v.bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      ifa.arm_i      = v.disturb && (c == 2);
      if (ifa.rd_valid_o && ifa.rd_ready_i) begin
        ei = 16'(v.base + got);
        eq = -ei;
        chk({v.name, "_rd_i"}, 32'(ifa.rd_i_o), 32'(ei));
        chk({v.name, "_rd_q"}, 32'(ifa.rd_q_o), 32'(eq));
        chk({v.name, "_rd_last"}, 32'(ifa.rd_last_o), 32'(got == v.exp_count - 1));
        got++;
      end
      pstall = ifa.rd_valid_o && !ifa.rd_ready_i;
      pi = ifa.rd_i_o;
      pq = ifa.rd_q_o;
      @(negedge clk);
    end
    ifa.rd_ready_i = 1'b0;
    ifa.arm_i = 1'b0;
    chk({v.name, "_drained"}, 32'(got), 32'(v.exp_count));
    chk({v.name, "_done_pulses"}, 32'(dones), 32'd1);
    chk({v.name, "_count"}, 32'(ifa.rd_count_o), 32'(v.exp_count));
    chk({v.name, "_trunc"}, 32'(ifa.trunc_o), 32'(v.exp_trunc));
    chk({v.name, "_busy_end"}, 32'(ifa.busy_o), 32'd0);
    chk({v.name, "_valid_end"}, 32'(ifa.rd_valid_o), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"full",    3, 8,  0, 'h0000, 1'b0, 1'b0, 8, 1'b0};
    vecs[1] = '{"bp",      0, 8,  0, 'h0064, 1'b1, 1'b0, 8, 1'b0};
    vecs[2] = '{"eof5",    1, 8,  5, 'h0040, 1'b0, 1'b0, 5, 1'b1};
    vecs[3] = '{"disturb", 2, 10, 0, 'h0300, 1'b0, 1'b1, 8, 1'b0};

    rst = 1'b1;
    clear_a();
    ifa.rd_ready_i = 1'b0;
    ifb.data_en_i = 1'b0; ifb.data_sof_i = 1'b0; ifb.data_eof_i = 1'b0;
    ifb.data_i_i = '0; ifb.data_q_i = '0; ifb.arm_i = 1'b0; ifb.rd_ready_i = 1'b0;
    #12;
    chk("rst_valid", 32'(ifa.rd_valid_o), 32'd0);
    chk("rst_last",  32'(ifa.rd_last_o), 32'd0);
    chk("rst_busy",  32'(ifa.busy_o), 32'd0);
    chk("rst_trunc", 32'(ifa.trunc_o), 32'd0);
    chk("rst_done",  32'(ifa.done_o), 32'd0);
    chk("rst_count", 32'(ifa.rd_count_o), 32'd0);
    chk("rst_data",  {ifa.rd_i_o, ifa.rd_q_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 4; r++) run_row(vecs[r]);

    // async reset in the middle of a drain
    @(negedge clk);
    ifa.arm_i = 1'b1;
    @(negedge clk);
    ifa.arm_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ifa.data_en_i = 1'b1;
      ifa.data_sof_i = (k == 0);
      ifa.data_i_i = 16'(k + 9);
      ifa.data_q_i = 16'(k + 9);
      @(negedge clk);
    end
    clear_a();
    ifa.rd_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    ifa.rd_ready_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(ifa.rd_valid_o), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ifa.rd_valid_o), 32'd0);
    chk("mid_rst_busy",  32'(ifa.busy_o), 32'd0);
    chk("mid_rst_count", 32'(ifa.rd_count_o), 32'd0);
    chk("mid_rst_last",  32'(ifa.rd_last_o), 32'd0);
    chk("mid_rst_data",  {ifa.rd_i_o, ifa.rd_q_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_row(vecs[0]);

    // FRAME_LEN=1, free-running start, gapped enable
    @(negedge clk);
    ifb.arm_i = 1'b1;
    @(negedge clk);
    ifb.arm_i = 1'b0;
    repeat (2) @(negedge clk);
    ifb.data_en_i = 1'b1;
    ifb.data_i_i = 16'h0055;
    ifb.data_q_i = 16'hFFAA;
    @(negedge clk);
    ifb.data_i_i = 16'h0011;
    ifb.data_q_i = 16'h0022;
    chk("b_valid_1cyc", 32'(ifb.rd_valid_o), 32'd0);
    @(negedge clk);
    ifb.data_en_i = 1'b0;
    chk("b_valid_2cyc", 32'(ifb.rd_valid_o), 32'd1);
    chk("b_rd_i",  32'(ifb.rd_i_o), 32'h0055);
    chk("b_rd_q",  32'(ifb.rd_q_o), 32'hFFAA);
    chk("b_last",  32'(ifb.rd_last_o), 32'd1);
    chk("b_count", 32'(ifb.rd_count_o), 32'd1);
    chk("b_trunc", 32'(ifb.trunc_o), 32'd0);
    ifb.rd_ready_i = 1'b1;
    @(negedge clk);
    ifb.rd_ready_i = 1'b0;
    chk("b_done",      32'(ifb.done_o), 32'd1);
    chk("b_valid_end", 32'(ifb.rd_valid_o), 32'd0);
    chk("b_busy_end",  32'(ifb.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
